// File: rtl/crossbar_sched_pkg.sv
// Shared constants, FSM states and flat-index helper for the 4x4 crossbar scheduler.
// The matrix layout is flattened as ingress*NUM_PORTS + egress.
package crossbar_sched_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;
    localparam int LEN_W     = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MATCH,
        S_GRANT,
        S_XFER
    } sched_state_t;

    function automatic int flat_idx(input int i, input int j);
        return i * NUM_PORTS + j;
    endfunction

endpackage

// File: rtl/crossbar_sched_rr_pick.sv
// Round-robin picker: returns the first set request at or after the pointer,
// wrapping modulo NUM_PORTS.
module rr_pick
    import crossbar_sched_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PORT_W-1:0]    i_ptr,
    output logic [PORT_W-1:0]    o_idx,
    output logic                 o_found
);

    logic [PORT_W-1:0] w_cand;

    // Walk from the farthest candidate back to the pointer so the nearest one wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_cand = PORT_W'((int'(i_ptr) + k) % NUM_PORTS);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossbar_sched.sv
// Slot-based crossbar scheduler: snapshot VOQ requests, match one egress per
// cycle with per-egress round-robin pointers, grant, then hold for the longest packet.
module crossbar_sched
    import crossbar_sched_pkg::*;
(
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]         i_voq_req,
    input  logic [NUM_PORTS*NUM_PORTS*LEN_W-1:0]   i_voq_len,
    input  logic [NUM_PORTS-1:0]                   i_egress_full,
    output logic [NUM_PORTS*NUM_PORTS-1:0]         o_grant,
    output logic                                   o_grant_valid,
    output logic                                   o_xfer_en,
    output logic                                   o_xfer_done,
    output logic                                   o_busy
);

    sched_state_t r_state, w_next;

    logic [NUM_PORTS*NUM_PORTS-1:0]         r_req_snap;
    logic [NUM_PORTS*NUM_PORTS*LEN_W-1:0]   r_len_snap;
    logic [NUM_PORTS-1:0]                   r_matched_in;
    logic [NUM_PORTS-1:0]                   r_match_vld;
    logic [NUM_PORTS-1:0][PORT_W-1:0]       r_match;
    logic [NUM_PORTS-1:0][PORT_W-1:0]       r_rr_ptr;
    logic [PORT_W-1:0]                      r_j;
    logic [LEN_W-1:0]                       r_slot_cnt;

    logic [NUM_PORTS*NUM_PORTS-1:0]         w_elig;
    logic                                   w_any;
    logic [NUM_PORTS-1:0]                   w_col;
    logic [PORT_W-1:0]                      w_pick;
    logic                                   w_found;
    logic [LEN_W-1:0]                       w_len;
    logic [LEN_W-1:0]                       w_max_len;
    logic [NUM_PORTS*NUM_PORTS-1:0]         w_grant_mat;

    // Replicating egress_full lines each copy up with the egress column of every row.
    assign w_elig = i_voq_req & ~{NUM_PORTS{i_egress_full}};
    assign w_any  = |w_elig;

    // Ingresses still free that requested the egress under consideration.
    always_comb begin
        w_col = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            w_col[i] = r_req_snap[flat_idx(i, int'(r_j))] & ~r_matched_in[i];
    end

    rr_pick u_rr_pick (
        .i_req   (w_col),
        .i_ptr   (r_rr_ptr[r_j]),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    // Zero-length packets still occupy one slot.
    always_comb begin
        w_max_len   = '0;
        w_len       = '0;
        w_grant_mat = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_len = r_len_snap[flat_idx(int'(r_match[j]), j)*LEN_W +: LEN_W];
            if (w_len == '0)
                w_len = LEN_W'(1);
            if (r_match_vld[j]) begin
                w_grant_mat[flat_idx(int'(r_match[j]), j)] = 1'b1;
                if (w_len > w_max_len)
                    w_max_len = w_len;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_MATCH;
            S_MATCH: if (r_j == PORT_W'(NUM_PORTS - 1)) w_next = S_GRANT;
            S_GRANT: w_next = S_XFER;
            S_XFER:  if (r_slot_cnt == LEN_W'(1)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_grant       = (r_state == S_GRANT || r_state == S_XFER) ? w_grant_mat : '0;
        o_grant_valid = (r_state == S_GRANT);
        o_xfer_en     = (r_state == S_XFER);
        o_xfer_done   = (r_state == S_XFER) && (r_slot_cnt == LEN_W'(1));
        o_busy        = (r_state != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_req_snap   <= '0;
            r_len_snap   <= '0;
            r_matched_in <= '0;
            r_match_vld  <= '0;
            r_match      <= '0;
            r_rr_ptr     <= '0;
            r_j          <= '0;
            r_slot_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_req_snap   <= w_elig;
                        r_len_snap   <= i_voq_len;
                        r_matched_in <= '0;
                        r_match_vld  <= '0;
                        r_j          <= '0;
                    end
                end
                S_MATCH: begin
                    if (w_found) begin
                        r_match[r_j]         <= w_pick;
                        r_match_vld[r_j]     <= 1'b1;
                        r_matched_in[w_pick] <= 1'b1;
                    end
                    r_j <= r_j + 1'b1;
                end
                S_GRANT: begin
                    r_slot_cnt <= w_max_len;
                    for (int j = 0; j < NUM_PORTS; j++)
                        if (r_match_vld[j])
                            r_rr_ptr[j] <= PORT_W'((int'(r_match[j]) + 1) % NUM_PORTS);
                end
                S_XFER: r_slot_cnt <= r_slot_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
